// File: rtl/clkctrl_sched_if.sv
// clkctrl_sched_if: request/feedback bundle between the clock scheduler,
// its software/hardware requesters and the dual-clock switch.
// master = requester side plus switch feedback, slave = scheduler.
interface clkctrl_sched_if;
  logic       turbo_en;
  logic       slow_req;
  logic       div_sel_wr;
  logic [1:0] div_sel_req;
  logic       hsclk_selected_in;
  logic       lsclk_selected_in;
  logic       hsclk_sel;
  logic [1:0] cpuclk_div_sel;
  logic       slow_ack;
  logic       busy;
  logic       timeout_err;

  modport master (
    output turbo_en, slow_req, div_sel_wr, div_sel_req,
           hsclk_selected_in, lsclk_selected_in,
    input  hsclk_sel, cpuclk_div_sel, slow_ack, busy, timeout_err
  );

  modport slave (
    input  turbo_en, slow_req, div_sel_wr, div_sel_req,
           hsclk_selected_in, lsclk_selected_in,
    output hsclk_sel, cpuclk_div_sel, slow_ack, busy, timeout_err
  );
endinterface

// File: rtl/clkctrl_sched.sv
// clkctrl_sched: sequencer for the dual-clock CPU clock switch.
// Arbitrates slow-access requests, divider writes and turbo permission,
// and only starts a new clock transition once the switch has confirmed
// the previous one. Everything runs on hsclk_in; switch feedback is
// resynchronised internally.
// Optional handshake watchdog: define CLKSCHED_TIMEOUT_EN.
module clkctrl_sched #(
  parameter int LS_DWELL    = 16,
  parameter int SW_TIMEOUT  = 255,
  parameter int SYNC_STAGES = 2
) (
  input  logic            hsclk_in,
  input  logic            rst_b,
  clkctrl_sched_if.slave  bus
);

  typedef enum logic [1:0] {
    LS_RUN = 2'd0,
    TO_HS  = 2'd1,
    HS_RUN = 2'd2,
    TO_LS  = 2'd3
  } state_t;

  localparam logic [7:0] DWELL_INIT = 8'(LS_DWELL);

  state_t                 state;
  state_t                 state_nxt;
  logic [SYNC_STAGES-1:0] hs_sync;
  logic [SYNC_STAGES-1:0] ls_sync;
  logic                   hs_s;
  logic                   ls_s;
  logic                   div_pend;
  logic [1:0]             div_code;
  logic [1:0]             div_nxt;
  logic [7:0]             dwell_cnt;
  logic                   apply_div;
  logic                   dwell_reload;
  logic                   hsclk_sel_q;
  logic [1:0]             div_sel_q;
  logic                   slow_ack_q;
  logic                   busy_q;
  logic                   to_hit;
  logic                   hs_inhibit;

  assign hs_s = hs_sync[SYNC_STAGES-1];
  assign ls_s = ls_sync[SYNC_STAGES-1];

  // Resynchronise the switch feedback; reset matches the switch's own reset (LS selected).
  always_ff @(posedge hsclk_in or negedge rst_b) begin
    if (!rst_b) begin
      hs_sync <= '0;
      ls_sync <= '1;
    end else begin
      hs_sync <= {hs_sync[SYNC_STAGES-2:0], bus.hsclk_selected_in};
      ls_sync <= {ls_sync[SYNC_STAGES-2:0], bus.lsclk_selected_in};
    end
  end

  // Next-state decision: slow_req beats a pending divider, which beats turbo.
  always_comb begin
    state_nxt    = state;
    apply_div    = 1'b0;
    dwell_reload = 1'b0;
    case (state)
      LS_RUN: begin
        if (div_pend) begin
          apply_div    = 1'b1;
          dwell_reload = 1'b1;
        end else if (bus.turbo_en && !bus.slow_req && (dwell_cnt == 8'd0) && !hs_inhibit) begin
          state_nxt = TO_HS;
        end
      end
      TO_HS: begin
        if (to_hit) begin
          state_nxt = TO_LS;
        end else if (hs_s && !ls_s) begin
          state_nxt = HS_RUN;
        end
      end
      HS_RUN: begin
        if (bus.slow_req || !bus.turbo_en || div_pend) begin
          state_nxt = TO_LS;
        end
      end
      TO_LS: begin
        if (ls_s && !hs_s) begin
          state_nxt    = LS_RUN;
          dwell_reload = 1'b1;
        end
      end
      default: state_nxt = LS_RUN;
    endcase
    div_nxt = apply_div ? div_code : div_sel_q;
  end

  // State, divider bookkeeping, dwell timer and all registered outputs.
  always_ff @(posedge hsclk_in or negedge rst_b) begin
    if (!rst_b) begin
      state       <= LS_RUN;
      hsclk_sel_q <= 1'b0;
      div_sel_q   <= 2'b10;
      slow_ack_q  <= 1'b0;
      busy_q      <= 1'b0;
      div_pend    <= 1'b0;
      div_code    <= 2'b10;
      dwell_cnt   <= DWELL_INIT;
    end else begin
      state       <= state_nxt;
      hsclk_sel_q <= (state_nxt == TO_HS) || (state_nxt == HS_RUN);
      busy_q      <= (state_nxt == TO_HS) || (state_nxt == TO_LS);
      slow_ack_q  <= (state_nxt == LS_RUN) && bus.slow_req;
      div_sel_q   <= div_nxt;
      if (bus.div_sel_wr) begin
        div_code <= bus.div_sel_req;
        div_pend <= (bus.div_sel_req != div_nxt);
      end else if (apply_div) begin
        div_pend <= 1'b0;
      end
      if (dwell_reload) begin
        dwell_cnt <= DWELL_INIT;
      end else if ((state == LS_RUN) && (dwell_cnt != 8'd0)) begin
        dwell_cnt <= dwell_cnt - 8'd1;
      end
    end
  end

`ifdef CLKSCHED_TIMEOUT_EN
  localparam logic [7:0] TO_LIMIT = 8'(SW_TIMEOUT);

  logic [7:0] to_cnt;
  logic       to_err_q;
  logic       inhibit_q;

  assign to_hit      = ((state == TO_HS) || (state == TO_LS)) && (to_cnt == TO_LIMIT);
  assign hs_inhibit  = inhibit_q;
  assign bus.timeout_err = to_err_q;

  // Handshake watchdog: a stuck HS entry falls back to LS and locks HS out until reset.
  always_ff @(posedge hsclk_in or negedge rst_b) begin
    if (!rst_b) begin
      to_cnt    <= 8'd0;
      to_err_q  <= 1'b0;
      inhibit_q <= 1'b0;
    end else begin
      if (((state_nxt == TO_HS) && (state != TO_HS)) ||
          ((state_nxt == TO_LS) && (state != TO_LS))) begin
        to_cnt <= 8'd0;
      end else if (((state == TO_HS) || (state == TO_LS)) && (to_cnt != TO_LIMIT)) begin
        to_cnt <= to_cnt + 8'd1;
      end
      if (to_hit) begin
        to_err_q <= 1'b1;
      end
      if (to_hit && (state == TO_HS)) begin
        inhibit_q <= 1'b1;
      end
    end
  end
`else
  // Without the watchdog handshakes wait forever; the limit comparison is constant false.
  assign to_hit          = (SW_TIMEOUT < 0);
  assign hs_inhibit      = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

  assign bus.hsclk_sel      = hsclk_sel_q;
  assign bus.cpuclk_div_sel = div_sel_q;
  assign bus.slow_ack       = slow_ack_q;
  assign bus.busy           = busy_q;

endmodule

// File: tb/tb_clkctrl_sched.sv
// tb_clkctrl_sched: directed bench for clkctrl_sched. A small switch model
// returns hsclk_sel on the feedback lines three cycles later (LS = !HS);
// fb_block can pin the HS feedback low to model a stuck switch.
module tb_clkctrl_sched;

  logic       clk;
  logic       rst_b;
  logic       fb_block;
  logic [2:0] fb_dly;
  int         checks;
  int         failures;

  clkctrl_sched_if bus ();

  clkctrl_sched #(
    .LS_DWELL    (16),
    .SW_TIMEOUT  (255),
    .SYNC_STAGES (2)
  ) dut (
    .hsclk_in (clk),
    .rst_b    (rst_b),
    .bus      (bus)
  );

  // Free-running 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Switch model: feedback follows hsclk_sel with three cycles of delay.
  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) fb_dly <= 3'b000;
    else        fb_dly <= {fb_dly[1:0], bus.hsclk_sel};
  end

  assign bus.hsclk_selected_in = fb_dly[2] & !fb_block;
  assign bus.lsclk_selected_in = !fb_dly[2];

  // Hard stop if the run ever wedges.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic turbo, input logic slow, input logic wr, input logic [1:0] code);
    bus.turbo_en    = turbo;
    bus.slow_req    = slow;
    bus.div_sel_wr  = wr;
    bus.div_sel_req = code;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Count consecutive busy samples starting from the current (busy) one.
  task automatic runBusy(input string tag, input int expCycles);
    int cnt;
    cnt = 1;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      if (bus.busy) cnt++;
      else break;
    end
    checkOutput(tag, cnt, expCycles);
  endtask

  initial begin
    int n;
    int seenHs;
    checks   = 0;
    failures = 0;
    fb_block = 1'b0;
    rst_b    = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b00);

    // Scenario 1: reset values, then first HS entry.
    tick(2);
    checkOutput("rst_hsclk_sel", bus.hsclk_sel, 1'b0);
    checkOutput("rst_div", bus.cpuclk_div_sel, 2'b10);
    checkOutput("rst_slow_ack", bus.slow_ack, 1'b0);
    checkOutput("rst_busy", bus.busy, 1'b0);
    checkOutput("rst_timeout_err", bus.timeout_err, 1'b0);
    rst_b = 1'b1;
    tick(16);
    checkOutput("s1_dwell_hold", bus.hsclk_sel, 1'b0);
    tick(1);
    checkOutput("s1_hsclk_rise", bus.hsclk_sel, 1'b1);
    checkOutput("s1_busy_rise", bus.busy, 1'b1);
    runBusy("s1_to_hs_len", 6);
    checkOutput("s1_hs_run", bus.hsclk_sel, 1'b1);

    // Scenario 2: slow access from HS_RUN.
    applyStimulus(1'b1, 1'b1, 1'b0, 2'b00);
    tick(1);
    checkOutput("s2_hsclk_drop", bus.hsclk_sel, 1'b0);
    checkOutput("s2_ack_not_yet", bus.slow_ack, 1'b0);
    tick(5);
    checkOutput("s2_ack_early", bus.slow_ack, 1'b0);
    checkOutput("s2_busy_to_ls", bus.busy, 1'b1);
    tick(1);
    checkOutput("s2_ack_rise", bus.slow_ack, 1'b1);
    checkOutput("s2_busy_done", bus.busy, 1'b0);
    tick(3);
    checkOutput("s2_ack_held", bus.slow_ack, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b00);
    tick(1);
    checkOutput("s2_ack_drop", bus.slow_ack, 1'b0);
    tick(12);
    checkOutput("s2_dwell_hold", bus.hsclk_sel, 1'b0);
    tick(1);
    checkOutput("s2_back_to_hs", bus.hsclk_sel, 1'b1);
    runBusy("s2_to_hs_len", 6);

    // Scenario 3: divider write from HS_RUN.
    applyStimulus(1'b1, 1'b0, 1'b1, 2'b01);
    tick(1);
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b00);
    checkOutput("s3_still_hs", bus.hsclk_sel, 1'b1);
    tick(1);
    checkOutput("s3_hsclk_drop", bus.hsclk_sel, 1'b0);
    checkOutput("s3_div_not_in_to_ls", bus.cpuclk_div_sel, 2'b10);
    runBusy("s3_to_ls_len", 6);
    checkOutput("s3_div_at_ls_entry", bus.cpuclk_div_sel, 2'b10);
    tick(1);
    checkOutput("s3_div_applied", bus.cpuclk_div_sel, 2'b01);
    tick(16);
    checkOutput("s3_dwell_hold", bus.hsclk_sel, 1'b0);
    tick(1);
    checkOutput("s3_back_to_hs", bus.hsclk_sel, 1'b1);
    runBusy("s3_to_hs_len", 6);
    applyStimulus(1'b1, 1'b0, 1'b1, 2'b01);
    tick(1);
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b00);
    tick(3);
    checkOutput("s3_same_write_hs", bus.hsclk_sel, 1'b1);
    checkOutput("s3_same_write_busy", bus.busy, 1'b0);
    checkOutput("s3_same_write_div", bus.cpuclk_div_sel, 2'b01);

    // Scenario 6: reset asserted in the middle of TO_HS.
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b00);
    tick(1);
    checkOutput("s6_turbo_off_busy", bus.busy, 1'b1);
    runBusy("s6_to_ls_len", 6);
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b00);
    tick(16);
    checkOutput("s6_dwell_hold", bus.hsclk_sel, 1'b0);
    tick(1);
    checkOutput("s6_in_to_hs", bus.busy, 1'b1);
    tick(2);
    #2;
    rst_b = 1'b0;
    #1;
    checkOutput("s6_async_hsclk_sel", bus.hsclk_sel, 1'b0);
    checkOutput("s6_async_busy", bus.busy, 1'b0);
    checkOutput("s6_async_div", bus.cpuclk_div_sel, 2'b10);
    checkOutput("s6_async_slow_ack", bus.slow_ack, 1'b0);
    tick(2);
    rst_b = 1'b1;
    tick(16);
    checkOutput("s6_rel_dwell_hold", bus.hsclk_sel, 1'b0);
    tick(1);
    checkOutput("s6_rel_hsclk_rise", bus.hsclk_sel, 1'b1);

    // Scenario 4: writes and slow_req while TO_HS is in progress.
    applyStimulus(1'b1, 1'b0, 1'b1, 2'b00);
    tick(1);
    applyStimulus(1'b1, 1'b0, 1'b1, 2'b01);
    tick(1);
    applyStimulus(1'b1, 1'b1, 1'b0, 2'b00);
    tick(1);
    checkOutput("s4_no_abort_busy", bus.busy, 1'b1);
    checkOutput("s4_no_ack_in_to_hs", bus.slow_ack, 1'b0);
    checkOutput("s4_div_unchanged", bus.cpuclk_div_sel, 2'b10);
    tick(3);
    checkOutput("s4_hs_run_reached", bus.hsclk_sel, 1'b1);
    checkOutput("s4_hs_run_busy", bus.busy, 1'b0);
    checkOutput("s4_no_ack_in_hs", bus.slow_ack, 1'b0);
    tick(1);
    checkOutput("s4_to_ls_start", bus.hsclk_sel, 1'b0);
    tick(5);
    checkOutput("s4_no_ack_in_to_ls", bus.slow_ack, 1'b0);
    tick(1);
    checkOutput("s4_ack_in_ls", bus.slow_ack, 1'b1);
    checkOutput("s4_div_at_ls_entry", bus.cpuclk_div_sel, 2'b10);
    tick(1);
    checkOutput("s4_last_code_applied", bus.cpuclk_div_sel, 2'b01);
    checkOutput("s4_ack_still", bus.slow_ack, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b00);
    tick(1);
    checkOutput("s4_ack_drop", bus.slow_ack, 1'b0);
    checkOutput("s4_div_kept", bus.cpuclk_div_sel, 2'b01);

`ifdef CLKSCHED_TIMEOUT_EN
    // Scenario 5: switch never confirms HS.
    fb_block = 1'b1;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.hsclk_sel) break;
      tick(1);
    end
    checkOutput("s5_hs_requested", bus.hsclk_sel, 1'b1);
    checkOutput("s5_err_before", bus.timeout_err, 1'b0);
    for (int i = 0; i < 400; i++) begin
      tick(1);
      n++;
      if (!bus.hsclk_sel) break;
    end
    checkOutput("s5_timeout_cycles", n, 256);
    checkOutput("s5_timeout_err", bus.timeout_err, 1'b1);
    fb_block = 1'b0;
    seenHs = 0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (bus.hsclk_sel) seenHs = 1;
    end
    checkOutput("s5_hs_inhibited", seenHs, 0);
    checkOutput("s5_err_sticky", bus.timeout_err, 1'b1);
`else
    n = 0;
    seenHs = 0;
    tick(20);
    checkOutput("end_timeout_err_tied", bus.timeout_err, 1'b0);
    checkOutput("end_hs_reentered", bus.hsclk_sel, 1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
